// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: mode encodings, default geometry and stage-count helper shared with the display path
package pipelined_adder_pkg;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;
    function automatic int num_stages(input int width, input int chunk);
        return width / chunk;
    endfunction
endpackage

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result valid-ready bundle between operand source, adder and display driver
interface pipelined_adder_if
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             i_valid;
    logic             o_in_ready;
    logic             i_sub;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_valid;
    logic             i_out_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;
    logic             o_overflow;
    logic             o_zero;
    modport slave (
        input  i_valid, i_sub, i_a, i_b, i_out_ready,
        output o_in_ready, o_valid, o_sum, o_carry, o_overflow, o_zero
    );
    modport master (
        output i_valid, i_sub, i_a, i_b, i_out_ready,
        input  o_in_ready, o_valid, o_sum, o_carry, o_overflow, o_zero
    );
endinterface

// File: rtl/pipelined_adder_chunk_stage.sv
// pipelined_adder_chunk_stage: registered CHUNK-bit add slice with carry, valid bit and shift enable
module pipelined_adder_chunk_stage #(
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             c_o,
    output logic             valid_o
);
    logic [CHUNK:0]   add_d;
    logic [CHUNK-1:0] sum_q;
    logic             c_q;
    logic             valid_q;
    assign add_d = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q   <= '0;
            c_q     <= 1'b0;
            valid_q <= 1'b0;
        end else if (en_i) begin
            sum_q   <= add_d[CHUNK-1:0];
            c_q     <= add_d[CHUNK];
            valid_q <= valid_i;
        end
    end
    assign sum_o   = sum_q;
    assign c_o     = c_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract, one CHUNK-bit slice per stage, valid/ready with back-pressure
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input logic              clk,
    input logic              reset,
    pipelined_adder_if.slave bus
);
    localparam int NS = num_stages(WIDTH, CHUNK);
    if (WIDTH % CHUNK != 0) begin : g_bad_param
        $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
    end
    logic             adv;
    logic [WIDTH-1:0] b_cond;
    logic [WIDTH-1:0] a_q   [NS];
    logic [WIDTH-1:0] b_q   [NS];
    logic [WIDTH-1:0] res_q [NS];
    logic [WIDTH-1:0] res_w [NS];
    logic [CHUNK-1:0] sum_w [NS];
    logic             c_w   [NS];
    logic             v_w   [NS];
    assign adv = !v_w[NS-1] || bus.i_out_ready;
    assign bus.o_in_ready = adv;
    assign b_cond = (bus.i_sub == MODE_SUB) ? ~bus.i_b : bus.i_b;
    // Operands ride along with their stage; res_q holds the slices already finished upstream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NS; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                res_q[i] <= '0;
            end
        end else if (adv) begin
            a_q[0]   <= bus.i_a;
            b_q[0]   <= b_cond;
            res_q[0] <= '0;
            for (int i = 1; i < NS; i++) begin
                a_q[i]   <= a_q[i-1];
                b_q[i]   <= b_q[i-1];
                res_q[i] <= res_w[i-1];
            end
        end
    end
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            res_w[i] = res_q[i];
            res_w[i][i*CHUNK +: CHUNK] = sum_w[i];
        end
    end
    for (genvar k = 0; k < NS; k++) begin : g_stage
        logic [CHUNK-1:0] a_s;
        logic [CHUNK-1:0] b_s;
        logic             c_s;
        logic             v_s;
        if (k == 0) begin : g_first
            assign a_s = bus.i_a[CHUNK-1:0];
            assign b_s = b_cond[CHUNK-1:0];
            assign c_s = (bus.i_sub == MODE_SUB);
            assign v_s = bus.i_valid;
        end else begin : g_next
            assign a_s = a_q[k-1][k*CHUNK +: CHUNK];
            assign b_s = b_q[k-1][k*CHUNK +: CHUNK];
            assign c_s = c_w[k-1];
            assign v_s = v_w[k-1];
        end
        pipelined_adder_chunk_stage #(.CHUNK(CHUNK)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .en_i    (adv),
            .valid_i (v_s),
            .a_i     (a_s),
            .b_i     (b_s),
            .c_i     (c_s),
            .sum_o   (sum_w[k]),
            .c_o     (c_w[k]),
            .valid_o (v_w[k])
        );
    end
    assign bus.o_valid    = v_w[NS-1];
    assign bus.o_sum      = res_w[NS-1];
    assign bus.o_carry    = c_w[NS-1];
    assign bus.o_overflow = (a_q[NS-1][WIDTH-1] == b_q[NS-1][WIDTH-1]) &&
                            (res_w[NS-1][WIDTH-1] != a_q[NS-1][WIDTH-1]);
    // Qualified by valid so the cleared pipeline does not report a zero result
    assign bus.o_zero     = v_w[NS-1] && ~|res_w[NS-1];
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: random valid/ready traffic scored against an arithmetic reference model
module tb_pipelined_adder;
    import pipelined_adder_pkg::*;
    localparam int W = 16;
    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
        int           cyc;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    pipelined_adder_if #(.WIDTH(W)) bus();
    pipelined_adder #(.WIDTH(W), .CHUNK(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    exp_t         q[$];
    int           n_chk = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           pops = 0;
    bit           lat_en = 1'b0;
    logic [W-1:0] last_sum;
    logic [2:0]   last_flags;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        int ua, ub, sa, sb, r, rs;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = (s == MODE_SUB) ? ua - ub : ua + ub;
        rs = (s == MODE_SUB) ? sa - sb : sa + sb;
        e.s = r[W-1:0];
        e.c = (s == MODE_SUB) ? (ua >= ub) : (r > 65535);
        e.v = (rs > 32767) || (rs < -32768);
        e.z = (e.s == 0);
        e.cyc = 0;
        return e;
    endfunction
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic rdy, output bit acc);
        exp_t e;
        @(negedge clk);
        bus.i_valid = v;
        bus.i_a = a;
        bus.i_b = b;
        bus.i_sub = s;
        bus.i_out_ready = rdy;
        #1;
        cyc++;
        if (bus.o_valid && rdy) begin
            if (q.size() == 0) check("spurious_out", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                pops++;
                last_sum = bus.o_sum;
                last_flags = {bus.o_carry, bus.o_overflow, bus.o_zero};
                check("sum", 32'(bus.o_sum), 32'(e.s));
                check("carry", 32'(bus.o_carry), 32'(e.c));
                check("overflow", 32'(bus.o_overflow), 32'(e.v));
                check("zero", 32'(bus.o_zero), 32'(e.z));
                if (lat_en) check("latency", 32'(cyc - e.cyc), 32'd4);
            end
        end
        acc = v && bus.o_in_ready;
        if (acc) begin
            e = model(a, b, s);
            e.cyc = cyc;
            q.push_back(e);
        end
    endtask
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input string tag,
                          input logic [W-1:0] es, input logic ec, input logic ev, input logic ez);
        bit acc;
        int p0;
        p0 = pops;
        step(1'b1, a, b, s, 1'b1, acc);
        check({tag, "_accept"}, 32'(acc), 32'd1);
        for (int t = 0; t < 12 && pops == p0; t++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        check({tag, "_done"}, 32'(pops - p0), 32'd1);
        check({tag, "_sum"}, 32'(last_sum), 32'(es));
        check({tag, "_flags"}, 32'(last_flags), 32'({ec, ev, ez}));
    endtask
    initial begin
        logic [W-1:0] la [6];
        logic         ls [6];
        logic [W-1:0] lb [6];
        logic [W-1:0] hs, ra, rb;
        logic [2:0]   hf;
        logic         rs, rv, rdy;
        bit           acc, have;
        int           sent, p0;
        bus.i_valid = 1'b0;
        bus.i_a = '0;
        bus.i_b = '0;
        bus.i_sub = 1'b0;
        bus.i_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_sum", 32'(bus.o_sum), 32'd0);
        check("rst_carry", 32'(bus.o_carry), 32'd0);
        check("rst_ovf", 32'(bus.o_overflow), 32'd0);
        check("rst_zero", 32'(bus.o_zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        lat_en = 1'b1;
        run_op(16'h00FF, 16'h0001, MODE_ADD, "add_00ff", 16'h0100, 1'b0, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, MODE_ADD, "add_wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op(16'h7FFF, 16'h0001, MODE_ADD, "add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op(16'h0005, 16'h0007, MODE_SUB, "sub_borrow", 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, MODE_SUB, "sub_ovf", 16'h7FFF, 1'b1, 1'b1, 1'b0);
        lat_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            la[i] = 16'($urandom);
            lb[i] = 16'($urandom);
            ls[i] = 1'($urandom_range(0, 1));
        end
        sent = 0;
        p0 = pops;
        hs = '0;
        hf = '0;
        for (int t = 0; t < 30 && (sent < 6 || q.size() > 0); t++) begin
            rdy = !(t >= 4 && t <= 6);
            step(sent < 6, la[sent % 6], lb[sent % 6], ls[sent % 6], rdy, acc);
            if (acc) sent++;
            if (t == 4) begin
                check("stall_first_valid", 32'(bus.o_valid), 32'd1);
                hs = bus.o_sum;
                hf = {bus.o_carry, bus.o_overflow, bus.o_zero};
            end
            if (t >= 4 && t <= 6) check("stall_in_ready", 32'(bus.o_in_ready), 32'd0);
            if (t >= 5 && t <= 6) begin
                check("stall_sum_hold", 32'(bus.o_sum), 32'(hs));
                check("stall_flags_hold", 32'({bus.o_carry, bus.o_overflow, bus.o_zero}), 32'(hf));
            end
        end
        check("b2b_count", 32'(pops - p0), 32'd6);
        check("b2b_empty", 32'(q.size()), 32'd0);
        sent = 0;
        p0 = pops;
        have = 1'b0;
        ra = '0;
        rb = '0;
        rs = 1'b0;
        for (int t = 0; t < 60000 && (sent < 10000 || q.size() > 0); t++) begin
            if (!have) begin
                ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                rb = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                rs = 1'($urandom_range(0, 1));
                have = 1'b1;
            end
            rv = (sent < 10000) && ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 3) != 0);
            step(rv, ra, rb, rs, rdy, acc);
            if (acc) begin
                sent++;
                have = 1'b0;
            end
        end
        check("rand_sent", 32'(sent), 32'd10000);
        check("rand_count", 32'(pops - p0), 32'd10000);
        check("rand_empty", 32'(q.size()), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 16'(i + 1), 16'h0100, MODE_ADD, 1'b1, acc);
        @(posedge clk);
        #1;
        check("pre_rst_valid", 32'(bus.o_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.o_valid), 32'd0);
        check("mid_rst_sum", 32'(bus.o_sum), 32'd0);
        check("mid_rst_carry", 32'(bus.o_carry), 32'd0);
        check("mid_rst_ovf", 32'(bus.o_overflow), 32'd0);
        check("mid_rst_zero", 32'(bus.o_zero), 32'd0);
        q.delete();
        bus.i_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        lat_en = 1'b1;
        run_op(16'h1234, 16'h1111, MODE_ADD, "post_rst", 16'h2345, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        check("post_rst_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
